alu_iter_exec: RTL and testbench
================================

// Module: alu_iter_exec
// PURPOSE
// - Execute-stage consumer of the 4-bit ALU operation code from the ALU controller: takes Operation + operands, returns result/branch flag.
// - Valid/ready on both sides. Shifts iterate 1 bit/cycle (area-cheap); all other ops complete in 1 cycle.
// - Sits between ID/EX register and EX/MEM register; hazard unit stalls on in_ready=0.
// PARAMETERS
// - DATA_WIDTH  32  operand/result width (power of 2, >=8)
// - SHW         $clog2(DATA_WIDTH)  shift-amount width; derived, not overridden
// PORTS
// - clk        in   1           rising-edge clock
// - reset      in   1           synchronous, active-high
// - in_valid   in   1           op + operands valid
// - in_ready   out  1           block accepts op this cycle
// - Operation  in   4           ALU op code (table below)
// - SrcA       in   DATA_WIDTH  operand A (rs1 / PC)
// - SrcB       in   DATA_WIDTH  operand B (rs2 / imm); SrcB[SHW-1:0] = shamt
// - out_valid  out  1           result valid; held until out_ready
// - out_ready  in   1           downstream accepts result
// - ALUResult  out  DATA_WIDTH  registered result
// - BrTaken    out  1           branch/jump taken (registered with ALUResult)
// - IllegalOp  out  1           Operation==4'b1100 (registered with ALUResult)
// - busy       out  1           state==SHIFT
// BEHAVIOUR
// - Reset: state=IDLE, out_valid=0, ALUResult=0, BrTaken=0, IllegalOp=0, busy=0, shift counter=0.
// - Op codes (ALUResult / BrTaken):
//   0000 AND A&B/0; 0001 OR A|B/0; 0010 ADD A+B/0; 0011 JAL A+B/1; 0100 SLT signed(A<B)?1:0 / 0;
//   0101 XOR A^B/0; 0110 SUB A-B/0; 0111 JALR (A+B)&~1 / 1;
//   1000 BEQ 0/(A==B); 1001 BNE 0/(A!=B); 1010 BLT 0/signed(A<B); 1011 BGE 0/signed(A>=B);
//   1100 illegal: 0/0, IllegalOp=1; 1101 SLL; 1110 SRL (zero fill); 1111 SRA (sign fill); shifts BrTaken=0.
// - Add/sub wrap modulo 2^DATA_WIDTH; no overflow flag. Shift amount = SrcB[SHW-1:0] only.
// - in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
// - FSM: IDLE, SHIFT.
//   IDLE, accept non-shift op or shift with shamt==0: result to output regs, out_valid=1 next cycle (latency 1).
//   IDLE, accept shift with shamt!=0: acc<=SrcA, cnt<=shamt, op latched, ->SHIFT.
//   SHIFT: acc shifted 1 bit per cycle, cnt--; on cycle with cnt==1 write final acc to ALUResult, out_valid=1, ->IDLE.
//   Shift latency = shamt+1 cycles from accept to out_valid (e.g. shamt 31 -> 32).
// - Output hold: while out_valid && !out_ready, ALUResult/BrTaken/IllegalOp stable; no new accept.
// - Simultaneous drain+accept in IDLE: old result leaves, new result appears next cycle; out_valid stays 1 (no bubble).
// - out_valid clears on out_ready when no new completion that cycle.
// - During SHIFT out_valid=0 (guaranteed: accept requires output free or draining).
// - in_valid dropped/operands changed during SHIFT: ignored (operands latched at accept).
// - reset mid-SHIFT or with out_valid=1: in-flight op and pending result discarded; reset values next cycle.
// CONFIGURATION
// - FAST_SHIFT_EN defined: SHIFT state unused; shifts use combinational barrel shifter, latency 1 like all ops; busy tied 0.
// - FAST_SHIFT_EN undefined: iterative shifter as above (default).
// - Result values identical in both builds; only latency and busy differ.
// TESTING
// - Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release, ALUResult=0.
// - ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> 1 cycle later out_valid=1, ALUResult=0, BrTaken=0; SUB 5-7 -> 0xFFFFFFFE.
// - SRA A=0x80000000 shamt=31 -> out_valid 32 cycles after accept, ALUResult=0xFFFFFFFF, in_ready=0 throughout; FAST_SHIFT_EN build: 1 cycle.
// - Backpressure: BLT A=0xFFFFFFFF B=1 with out_ready=0 for 5 cycles -> BrTaken=1 held stable, in_ready=0; back-to-back BGE same operands accepted on release cycle -> BrTaken=0 next cycle, no bubble.
// - JALR A=0x1003 B=0x10 -> ALUResult=0x1012, BrTaken=1; Operation=1100 -> IllegalOp=1, ALUResult=0.
// - Reset asserted mid-SLL (A=1, shamt=20, cycle 5) -> next cycle IDLE, out_valid=0; no result ever emitted for that op.

Source files
------------

// File: rtl/alu_iter_exec_if.sv
// Execute-stage handshake bundle: op/operand request channel and result channel.
// No latency of its own; purely wiring between ID/EX issue logic and the ALU.
// Backpressure: in_ready/out_ready carry stall information in each direction.
// Signals: in_valid/in_ready/Operation/SrcA/SrcB (request), out_valid/out_ready/
// ALUResult/BrTaken/IllegalOp (response), busy (iterative shift in progress).
interface alu_iter_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  BrTaken;
  logic                  IllegalOp;
  logic                  busy;

  // Issue side / consumer side (drives operands, accepts results).
  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, BrTaken, IllegalOp, busy
  );

  // ALU side.
  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, BrTaken, IllegalOp, busy
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU driven by the 4-bit ALU-controller op code; result + branch flag.
// Latency 1 cycle; shifts take shamt+1 cycles (1 with FAST_SHIFT_EN defined).
// Backpressure: result held while out_ready=0; in_ready=0 while shifting or output blocked.
// Ports: clk, reset (sync, active-high), io (alu_iter_exec_if.slave: in_valid/in_ready,
// Operation, SrcA, SrcB, out_valid/out_ready, ALUResult, BrTaken, IllegalOp, busy).
// Optional macro FAST_SHIFT_EN: replaces the 1-bit/cycle shifter with a barrel shifter.
module alu_iter_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  alu_iter_exec_if.slave      io
);
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [SHW-1:0]        cnt;
  logic [1:0]            sh_kind;   // Operation[1:0] of the latched shift: 01 SLL, 10 SRL, 11 SRA
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  br_q;
  logic                  ill_q;

  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic                  is_shift;
  logic                  go_shift;
  logic [DATA_WIDTH-1:0] sum;
  logic                  lt_s;
  logic [DATA_WIDTH-1:0] res;
  logic                  br;
  logic                  ill;
  logic [DATA_WIDTH-1:0] acc_next;

  // One-bit step of the iterative shifter for the latched shift kind.
  function automatic logic [DATA_WIDTH-1:0] shift1(input logic [1:0] kind,
                                                   input logic [DATA_WIDTH-1:0] v);
    case (kind)
      2'b01:   shift1 = {v[DATA_WIDTH-2:0], 1'b0};
      2'b10:   shift1 = {1'b0, v[DATA_WIDTH-1:1]};
      default: shift1 = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
    endcase
  endfunction

  assign shamt    = io.SrcB[SHW-1:0];
  assign is_shift = (io.Operation == 4'b1101) || (io.Operation == 4'b1110) ||
                    (io.Operation == 4'b1111);
  assign sum      = io.SrcA + io.SrcB;
  assign lt_s     = $signed(io.SrcA) < $signed(io.SrcB);
  assign acc_next = shift1(sh_kind, acc);

  // Issue is allowed only when idle and the output slot is free or draining now.
  assign io.in_ready = (state == IDLE) && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

`ifdef FAST_SHIFT_EN
  assign go_shift = 1'b0;
  assign io.busy  = 1'b0;
`else
  // A zero shift amount is just a copy of SrcA, so it takes the single-cycle path.
  assign go_shift = is_shift && (shamt != '0);
  assign io.busy  = (state == SHIFT);
`endif

  always_comb begin
    res = '0;
    br  = 1'b0;
    ill = 1'b0;
    case (io.Operation)
      4'b0000: res = io.SrcA & io.SrcB;
      4'b0001: res = io.SrcA | io.SrcB;
      4'b0010: res = sum;
      4'b0011: begin res = sum; br = 1'b1; end
      4'b0100: res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      4'b0101: res = io.SrcA ^ io.SrcB;
      4'b0110: res = io.SrcA - io.SrcB;
      4'b0111: begin res = {sum[DATA_WIDTH-1:1], 1'b0}; br = 1'b1; end
      4'b1000: br = (io.SrcA == io.SrcB);
      4'b1001: br = (io.SrcA != io.SrcB);
      4'b1010: br = lt_s;
      4'b1011: br = !lt_s;
      4'b1100: ill = 1'b1;
`ifdef FAST_SHIFT_EN
      4'b1101: res = io.SrcA << shamt;
      4'b1110: res = io.SrcA >> shamt;
      default: res = $unsigned($signed(io.SrcA) >>> shamt);
`else
      // Only reached with shamt==0 here; non-zero amounts go through SHIFT.
      default: res = io.SrcA;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      sh_kind     <= 2'b00;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.out_ready) out_valid_q <= 1'b0;
          if (accept) begin
            if (go_shift) begin
              acc     <= io.SrcA;
              cnt     <= shamt;
              sh_kind <= io.Operation[1:0];
              state   <= SHIFT;
            end else begin
              // Overrides the drain above: back-to-back results keep out_valid high.
              result_q    <= res;
              br_q        <= br;
              ill_q       <= ill;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q    <= acc_next;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.ALUResult = result_q;
  assign io.BrTaken   = br_q;
  assign io.IllegalOp = ill_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: reset, arithmetic, long shift, backpressure, jumps, reset mid-shift.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure is driven explicitly through out_ready in the relevant scenarios.
module tb_alu_iter_exec;
  logic clk;
  logic reset;
  int   checks;
  int   passed;

`ifdef FAST_SHIFT_EN
  localparam int SRA_LAT = 1;
  localparam bit BUSY_EXP = 1'b0;
`else
  localparam int SRA_LAT = 32;
  localparam bit BUSY_EXP = 1'b1;
`endif

  alu_iter_exec_if #(.DATA_WIDTH(32)) io ();

  alu_iter_exec #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one op and hold it until the accepting edge; ok=0 if in_ready never rose.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit ok);
    int n;
    n = 0;
    io.in_valid  = 1'b1;
    io.Operation = op;
    io.SrcA      = a;
    io.SrcB      = b;
    while (!io.in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    ok = io.in_ready;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    io.in_valid  = 1'b1;
    io.Operation = 4'b0010;
    io.SrcA      = 32'h1234_5678;
    io.SrcB      = 32'h1;
    io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", io.out_valid); else passed++;
    checks++; if (io.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", io.in_ready); else passed++;
    checks++; if (io.ALUResult !== 32'h0) $display("FAIL reset_result: got %h want 0", io.ALUResult); else passed++;
    checks++; if (io.BrTaken !== 1'b0 || io.IllegalOp !== 1'b0 || io.busy !== 1'b0)
      $display("FAIL reset_flags: got br=%b ill=%b busy=%b want 0/0/0", io.BrTaken, io.IllegalOp, io.busy);
    else passed++;
  endtask

  task automatic test_add_sub();
    bit ok;
    io.out_ready = 1'b1;
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, ok);
    checks++; if (!ok) $display("FAIL add_accept: got in_ready=0 want 1"); else passed++;
    checks++; if (io.out_valid !== 1'b1 || io.ALUResult !== 32'h0 || io.BrTaken !== 1'b0)
      $display("FAIL add_wrap: got v=%b r=%h br=%b want 1/00000000/0", io.out_valid, io.ALUResult, io.BrTaken);
    else passed++;
    issue(4'b0110, 32'd5, 32'd7, ok);
    checks++; if (!ok || io.out_valid !== 1'b1 || io.ALUResult !== 32'hFFFF_FFFE)
      $display("FAIL sub_wrap: got ok=%b v=%b r=%h want 1/1/fffffffe", ok, io.out_valid, io.ALUResult);
    else passed++;
    @(posedge clk); #1;
    checks++; if (io.out_valid !== 1'b0) $display("FAIL drain_clear: got %b want 0", io.out_valid); else passed++;
  endtask

  task automatic test_long_shift();
    bit ok;
    bit rdy_low;
    bit busy_ok;
    int lat;
    io.out_ready = 1'b1;
    rdy_low = 1'b1;
    // Upper SrcB bits must be ignored: low 5 bits of 0xFF give shamt 31.
    issue(4'b1111, 32'h8000_0000, 32'h0000_00FF, ok);
    busy_ok = (io.busy === BUSY_EXP);
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 60) begin
      if (io.in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != SRA_LAT) $display("FAIL sra_latency: got %0d want %0d", lat, SRA_LAT); else passed++;
    checks++; if (io.ALUResult !== 32'hFFFF_FFFF || io.BrTaken !== 1'b0)
      $display("FAIL sra_result: got %h br=%b want ffffffff/0", io.ALUResult, io.BrTaken);
    else passed++;
    checks++; if (!rdy_low) $display("FAIL sra_in_ready: got 1 during shift want 0"); else passed++;
    checks++; if (!busy_ok) $display("FAIL sra_busy: got %b want %b", !BUSY_EXP, BUSY_EXP); else passed++;
    @(posedge clk); #1;
    checks++; if (io.busy !== 1'b0 || io.out_valid !== 1'b0)
      $display("FAIL sra_done: got busy=%b v=%b want 0/0", io.busy, io.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit held;
    io.out_ready = 1'b0;
    issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, ok);
    // Next op waits at the input while the result is stalled.
    io.in_valid  = 1'b1;
    io.Operation = 4'b1011;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (io.out_valid !== 1'b1 || io.BrTaken !== 1'b1 || io.ALUResult !== 32'h0 || io.in_ready !== 1'b0)
        held = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!ok || !held) $display("FAIL blt_hold: got ok=%b held=%b want 1/1", ok, held); else passed++;
    io.out_ready = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", io.in_ready); else passed++;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b1 || io.BrTaken !== 1'b0)
      $display("FAIL bge_no_bubble: got v=%b br=%b want 1/0", io.out_valid, io.BrTaken);
    else passed++;
    @(posedge clk); #1;
    checks++; if (io.out_valid !== 1'b0) $display("FAIL bge_drain: got %b want 0", io.out_valid); else passed++;
  endtask

  task automatic test_jump_illegal();
    bit ok;
    io.out_ready = 1'b1;
    issue(4'b0111, 32'h0000_1003, 32'h0000_0010, ok);
    checks++; if (!ok || io.out_valid !== 1'b1 || io.ALUResult !== 32'h0000_1012 || io.BrTaken !== 1'b1)
      $display("FAIL jalr: got v=%b r=%h br=%b want 1/00001012/1", io.out_valid, io.ALUResult, io.BrTaken);
    else passed++;
    issue(4'b1100, 32'h0000_0005, 32'h0000_0006, ok);
    checks++; if (!ok || io.IllegalOp !== 1'b1 || io.ALUResult !== 32'h0 || io.BrTaken !== 1'b0)
      $display("FAIL illegal: got ill=%b r=%h br=%b want 1/00000000/0", io.IllegalOp, io.ALUResult, io.BrTaken);
    else passed++;
  endtask

  task automatic test_op_table();
    logic [3:0]  t_op  [11];
    logic [31:0] t_a   [11];
    logic [31:0] t_b   [11];
    logic [31:0] t_res [11];
    logic        t_br  [11];
    bit ok;
    int n;
    t_op[0]  = 4'b0000; t_a[0]  = 32'hF0F0_F0F0; t_b[0]  = 32'hFF00_FF00; t_res[0]  = 32'hF000_F000; t_br[0]  = 0;
    t_op[1]  = 4'b0001; t_a[1]  = 32'hF0F0_F0F0; t_b[1]  = 32'h0F0F_0000; t_res[1]  = 32'hFFFF_F0F0; t_br[1]  = 0;
    t_op[2]  = 4'b0101; t_a[2]  = 32'hAAAA_AAAA; t_b[2]  = 32'hFFFF_FFFF; t_res[2]  = 32'h5555_5555; t_br[2]  = 0;
    t_op[3]  = 4'b0100; t_a[3]  = 32'hFFFF_FFFE; t_b[3]  = 32'h0000_0001; t_res[3]  = 32'h0000_0001; t_br[3]  = 0;
    t_op[4]  = 4'b0100; t_a[4]  = 32'h0000_0001; t_b[4]  = 32'hFFFF_FFFE; t_res[4]  = 32'h0000_0000; t_br[4]  = 0;
    t_op[5]  = 4'b0011; t_a[5]  = 32'h0000_0100; t_b[5]  = 32'h0000_0004; t_res[5]  = 32'h0000_0104; t_br[5]  = 1;
    t_op[6]  = 4'b1000; t_a[6]  = 32'h0000_1234; t_b[6]  = 32'h0000_1234; t_res[6]  = 32'h0000_0000; t_br[6]  = 1;
    t_op[7]  = 4'b1001; t_a[7]  = 32'h0000_1234; t_b[7]  = 32'h0000_1234; t_res[7]  = 32'h0000_0000; t_br[7]  = 0;
    t_op[8]  = 4'b1011; t_a[8]  = 32'h0000_0007; t_b[8]  = 32'h0000_0007; t_res[8]  = 32'h0000_0000; t_br[8]  = 1;
    t_op[9]  = 4'b1101; t_a[9]  = 32'hDEAD_BEEF; t_b[9]  = 32'h0000_0020; t_res[9]  = 32'hDEAD_BEEF; t_br[9]  = 0;
    t_op[10] = 4'b1110; t_a[10] = 32'h8000_0000; t_b[10] = 32'h0000_0004; t_res[10] = 32'h0800_0000; t_br[10] = 0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], ok);
      n = 0;
      while (io.out_valid !== 1'b1 && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (!ok || io.out_valid !== 1'b1 || io.ALUResult !== t_res[i] || io.BrTaken !== t_br[i] || io.IllegalOp !== 1'b0)
        $display("FAIL op_table[%0d] op=%b: got v=%b r=%h br=%b ill=%b want 1/%h/%b/0",
                 i, t_op[i], io.out_valid, io.ALUResult, io.BrTaken, io.IllegalOp, t_res[i], t_br[i]);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    bit busy_ok;
    bit seen;
    io.out_ready = 1'b1;
    issue(4'b1101, 32'h0000_0001, 32'd20, ok);
    repeat (4) begin
      @(posedge clk); #1;
    end
    busy_ok = (io.busy === BUSY_EXP);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (!ok || !busy_ok) $display("FAIL sll_started: got ok=%b busy_ok=%b want 1/1", ok, busy_ok); else passed++;
    checks++; if (io.out_valid !== 1'b0 || io.busy !== 1'b0 || io.in_ready !== 1'b1 || io.ALUResult !== 32'h0)
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b r=%h want 0/0/1/0", io.out_valid, io.busy, io.in_ready, io.ALUResult);
    else passed++;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (io.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) $display("FAIL ghost_result: got out_valid=1 after reset want 0"); else passed++;
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.Operation = 4'b0000;
    io.SrcA      = 32'h0;
    io.SrcB      = 32'h0;
    io.out_ready = 1'b0;
    #1;
    test_reset();
    test_add_sub();
    test_long_shift();
    test_back_to_back();
    test_jump_illegal();
    test_op_table();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
